pic_cmd_sequencer: RTL and testbench
====================================

// Module: pic_cmd_sequencer
// PURPOSE
// CPU-side write/read front end of the 8259 PIC: turns raw bus strobes (cs_n, wr_n, rd_n, a0, data) into the
// command-word stream the control logic consumes. Walks ICW1->ICW2->[ICW3]->[ICW4] after every ICW1, then decodes OCW1/2/3.
// Emits a one-cycle flag+data per accepted word, and a read-select code (IMR/IRR/ISR) for the data-buffer readback path.
// PARAMETERS
// DATA_W      8      bus width; only 8 is supported
// FLAG_IDLE   3'd7   cmd_flag value when no word is being delivered
// PORTS
// clk            in   1  single clock; all logic on rising edge
// reset_n        in   1  synchronous, active-low reset
// cs_n           in   1  chip select, active low (synchronous to clk)
// wr_n           in   1  write strobe, active low
// rd_n           in   1  read strobe, active low
// a0             in   1  address bit
// data_in        in   8  CPU write data
// cmd_data       out  8  captured command word, valid with cmd_valid
// cmd_flag       out  3  0 ICW1,1 ICW2,2 ICW3,3 ICW4,4 OCW1,5 OCW2,6 OCW3; FLAG_IDLE otherwise
// cmd_valid      out  1  one-cycle pulse: cmd_flag/cmd_data are valid
// read_sel       out  3  3'b011 IMR, 3'b001 IRR, 3'b101 ISR, 3'b000 no read
// init_done      out  1  high once the ICW sequence is complete (state READY)
// seq_error      out  1  one-cycle pulse: write discarded as illegal in current state
// BEHAVIOUR
// - Reset (reset_n=0 at an edge): state=UNINIT, cmd_flag=FLAG_IDLE, cmd_valid=0, cmd_data=0, read_sel=0,
//   init_done=0, seq_error=0, sngl=0, ic4=0, rd_reg=IRR. Reset mid-sequence discards any pending write.
// - Write capture: each cycle wr_n=0: hold_a0/hold_data<=a0/data_in, hold_cs<=~cs_n. Write commits on the first cycle
//   wr_n samples 1 after having sampled 0, only if hold_cs=1 (last low-wr cycle had cs_n low). Last sampled data wins.
// - Latency: cmd_valid/cmd_flag/cmd_data/seq_error registered; asserted the cycle after wr_n is sampled high, exactly 1 cycle.
// - Decode of committed word (a0,d): ICW1 = a0=0 & d[4]=1, accepted in ANY state (restart): flag 0, sngl<=d[1],
//   ic4<=d[0], rd_reg<=IRR, init_done<=0, state<=WAIT_ICW2.
// - FSM: UNINIT --ICW1--> WAIT_ICW2; WAIT_ICW2 --a0=1: flag1--> WAIT_ICW3 if !sngl, else WAIT_ICW4 if ic4, else READY;
//   WAIT_ICW3 --a0=1: flag2--> WAIT_ICW4 if ic4 else READY; WAIT_ICW4 --a0=1: flag3--> READY.
// - READY: a0=1 -> OCW1 flag4; a0=0,d[4:3]=00 -> OCW2 flag5; a0=0,d[4:3]=01 -> OCW3 flag6,
//   and if d[1]=1 then rd_reg<=d[0]?ISR:IRR. init_done=1 only in READY.
// - Illegal: non-ICW1 word in UNINIT; a0=0 non-ICW1 word in WAIT_*; a0=0,d[4:3]=11 in READY ->
//   discarded, no cmd_valid, seq_error pulse, state unchanged.
// - Read: read_sel registered, 1-cycle latency; when cs_n=0 & rd_n=0 & wr_n=1: a0=1 -> IMR, a0=0 -> rd_reg code;
//   otherwise 3'b000. Reads allowed in any state.
// - rd_n and wr_n both low with cs_n low: write captured, read_sel=000 (write wins).
// - OCW3 changing rd_reg takes effect on reads sampled from the cycle after cmd_valid.
// STRUCTURE
// - pic_pkg: flag encodings (ICW1..OCW3, FLAG_IDLE), read_sel codes, sequencer state enum
//   (UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY).
// - One sub-module: pic_wr_strobe (write-hold regs + commit-pulse generation); FSM/decode/read select inline.
// TESTING
// - Reset, then ICW1=8'h13 (sngl=1, ic4=1), ICW2=8'h20, ICW4=8'h01 -> flags 0,1,3, each 1-cycle pulse; init_done=1 after ICW4.
// - Cascade: ICW1=8'h11, ICW2=8'h40, ICW3=8'h04, ICW4=8'h1D -> flags 0,1,2,3 with matching cmd_data; init_done=1.
// - READY: a0=1 8'hF0 -> flag4; a0=0 8'h20 -> flag5; a0=0 8'h0B -> flag6; then rd a0=0 -> read_sel=101, rd a0=1 -> 011.
// - In WAIT_ICW2 write a0=0 8'h0A -> seq_error pulse, no cmd_valid, next a0=1 write still yields flag1.
// - Mid-sequence ICW1 (8'h13 while WAIT_ICW4) -> flag0, back to WAIT_ICW2, rd_reg=IRR (rd a0=0 -> 001).
// - reset_n=0 while wr_n low, release; wr_n high -> no cmd_valid, state UNINIT, all outputs at reset values.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared encodings for the 8259 PIC command sequencer: command flags, read-select
// codes and the initialization sequencer states.
package pic_pkg;

    localparam int PIC_DATA_W = 8;

    typedef enum logic [2:0] {
        FLAG_ICW1 = 3'd0,
        FLAG_ICW2 = 3'd1,
        FLAG_ICW3 = 3'd2,
        FLAG_ICW4 = 3'd3,
        FLAG_OCW1 = 3'd4,
        FLAG_OCW2 = 3'd5,
        FLAG_OCW3 = 3'd6
    } cmd_flag_e;

    localparam logic [2:0] FLAG_IDLE_DEFAULT = 3'd7;

    localparam logic [2:0] RSEL_NONE = 3'b000;
    localparam logic [2:0] RSEL_IRR  = 3'b001;
    localparam logic [2:0] RSEL_IMR  = 3'b011;
    localparam logic [2:0] RSEL_ISR  = 3'b101;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU bus strobes into the sequencer and the decoded command stream out of it.
// master = CPU/bench side, slave = sequencer side.
interface pic_cmd_sequencer_if;
    import pic_pkg::*;

    logic                  cs_n;
    logic                  wr_n;
    logic                  rd_n;
    logic                  a0;
    logic [PIC_DATA_W-1:0] data_in;
    logic [PIC_DATA_W-1:0] cmd_data;
    logic [2:0]            cmd_flag;
    logic                  cmd_valid;
    logic [2:0]            read_sel;
    logic                  init_done;
    logic                  seq_error;

    modport master (
        output cs_n, wr_n, rd_n, a0, data_in,
        input  cmd_data, cmd_flag, cmd_valid, read_sel, init_done, seq_error
    );

    modport slave (
        input  cs_n, wr_n, rd_n, a0, data_in,
        output cmd_data, cmd_flag, cmd_valid, read_sel, init_done, seq_error
    );

endinterface

// File: rtl/pic_wr_strobe.sv
// Holds the address/data of a CPU write while wr_n is low and raises commit on the
// first cycle wr_n is seen high again, provided the last low cycle was chip-selected.
module pic_wr_strobe
    import pic_pkg::*;
#(
    parameter int DATA_W = PIC_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic              commit,
    output logic              hold_a0,
    output logic [DATA_W-1:0] hold_data
);

    logic wr_low_q;
    logic hold_cs;

    // Every low-wr cycle overwrites the hold registers, so the last sampled word wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_low_q  <= 1'b0;
            hold_cs   <= 1'b0;
            hold_a0   <= 1'b0;
            hold_data <= '0;
        end else begin
            wr_low_q <= ~wr_n;
            if (!wr_n) begin
                hold_a0   <= a0;
                hold_data <= data_in;
                hold_cs   <= ~cs_n;
            end
        end
    end

    assign commit = wr_low_q & wr_n & hold_cs;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259 PIC CPU front end: sequences ICW1..ICW4, decodes OCW1..OCW3 and produces
// the registered read-select code for IMR/IRR/ISR readback.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int         DATA_W    = PIC_DATA_W,
    parameter logic [2:0] FLAG_IDLE = FLAG_IDLE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    pic_cmd_sequencer_if.slave bus
);

    seq_state_e        state, state_nxt;
    logic [2:0]        flag_q, flag_nxt;
    logic              valid_q, valid_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              err_q, err_nxt;
    logic              sngl_q, sngl_nxt;
    logic              ic4_q, ic4_nxt;
    logic [2:0]        rd_reg_q, rd_reg_nxt;
    logic [2:0]        read_sel_q, read_sel_nxt;

    logic              commit;
    logic              hold_a0;
    logic [DATA_W-1:0] hold_data;
    logic              accept;
    logic              reject;
    logic [2:0]        acc_flag;

    pic_wr_strobe #(.DATA_W(DATA_W)) u_wr_strobe (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (bus.cs_n),
        .wr_n      (bus.wr_n),
        .a0        (bus.a0),
        .data_in   (bus.data_in),
        .commit    (commit),
        .hold_a0   (hold_a0),
        .hold_data (hold_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= UNINIT;
            flag_q     <= FLAG_IDLE;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            rd_reg_q   <= RSEL_IRR;
            read_sel_q <= RSEL_NONE;
        end else begin
            state      <= state_nxt;
            flag_q     <= flag_nxt;
            valid_q    <= valid_nxt;
            data_q     <= data_nxt;
            err_q      <= err_nxt;
            sngl_q     <= sngl_nxt;
            ic4_q      <= ic4_nxt;
            rd_reg_q   <= rd_reg_nxt;
            read_sel_q <= read_sel_nxt;
        end
    end

    // ICW1 (a0=0, d[4]=1) restarts initialization from any state; everything else
    // is judged against where the sequence currently stands.
    always_comb begin
        state_nxt  = state;
        sngl_nxt   = sngl_q;
        ic4_nxt    = ic4_q;
        rd_reg_nxt = rd_reg_q;
        accept     = 1'b0;
        reject     = 1'b0;
        acc_flag   = FLAG_IDLE;

        if (commit) begin
            if (!hold_a0 && hold_data[4]) begin
                accept     = 1'b1;
                acc_flag   = FLAG_ICW1;
                sngl_nxt   = hold_data[1];
                ic4_nxt    = hold_data[0];
                rd_reg_nxt = RSEL_IRR;
                state_nxt  = WAIT_ICW2;
            end else begin
                case (state)
                    UNINIT: reject = 1'b1;
                    WAIT_ICW2: begin
                        if (hold_a0) begin
                            accept   = 1'b1;
                            acc_flag = FLAG_ICW2;
                            if (!sngl_q)
                                state_nxt = WAIT_ICW3;
                            else if (ic4_q)
                                state_nxt = WAIT_ICW4;
                            else
                                state_nxt = READY;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (hold_a0) begin
                            accept    = 1'b1;
                            acc_flag  = FLAG_ICW3;
                            state_nxt = ic4_q ? WAIT_ICW4 : READY;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (hold_a0) begin
                            accept    = 1'b1;
                            acc_flag  = FLAG_ICW4;
                            state_nxt = READY;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    READY: begin
                        if (hold_a0) begin
                            accept   = 1'b1;
                            acc_flag = FLAG_OCW1;
                        end else begin
                            case (hold_data[4:3])
                                2'b00: begin
                                    accept   = 1'b1;
                                    acc_flag = FLAG_OCW2;
                                end
                                2'b01: begin
                                    accept   = 1'b1;
                                    acc_flag = FLAG_OCW3;
                                    if (hold_data[1])
                                        rd_reg_nxt = hold_data[0] ? RSEL_ISR : RSEL_IRR;
                                end
                                default: reject = 1'b1;
                            endcase
                        end
                    end
                    default: state_nxt = UNINIT;
                endcase
            end
        end

        flag_nxt  = acc_flag;
        valid_nxt = accept;
        data_nxt  = accept ? hold_data : data_q;
        err_nxt   = reject;

        // A simultaneous write strobe suppresses the read.
        read_sel_nxt = RSEL_NONE;
        if (!bus.cs_n && !bus.rd_n && bus.wr_n)
            read_sel_nxt = bus.a0 ? RSEL_IMR : rd_reg_q;
    end

    assign bus.cmd_flag  = flag_q;
    assign bus.cmd_valid = valid_q;
    assign bus.cmd_data  = data_q;
    assign bus.seq_error = err_q;
    assign bus.read_sel  = read_sel_q;
    assign bus.init_done = (state == READY);

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Scoreboard bench for pic_cmd_sequencer: directed init/OCW scenarios, then random
// bus traffic checked against a queue-based model of the initialization sequence.
module tb_pic_cmd_sequencer;

    typedef struct {
        int         kind;
        logic [2:0] code;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cycleCnt;
    int   checks;
    int   errors;

    exp_t expQ[$];

    bit   mStarted;
    int   mPending[$];
    bit   mRdIsr;

    pic_cmd_sequencer_if bus();

    pic_cmd_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic bit modelReady();
        return mStarted && (mPending.size() == 0);
    endfunction

    function automatic void modelReset();
        mStarted = 1'b0;
        mPending.delete();
        mRdIsr = 1'b0;
    endfunction

    function automatic void pushExp(input int kind, input int code, input logic [7:0] d, input int due);
        exp_t e;
        e.kind = kind;
        e.code = code[2:0];
        e.data = d;
        e.due  = due;
        expQ.push_back(e);
    endfunction

    // Model: ICW1 builds the list of ICWs still owed; once it is empty the OCWs apply.
    function automatic void modelWrite(input bit a0v, input logic [7:0] d, input int due);
        if (!a0v && d[4]) begin
            mStarted = 1'b1;
            mRdIsr   = 1'b0;
            mPending.delete();
            mPending.push_back(1);
            if (!d[1]) mPending.push_back(2);
            if (d[0])  mPending.push_back(3);
            pushExp(0, 0, d, due);
        end else if (!mStarted) begin
            pushExp(1, 0, d, due);
        end else if (mPending.size() != 0) begin
            if (a0v) pushExp(0, mPending.pop_front(), d, due);
            else     pushExp(1, 0, d, due);
        end else if (a0v) begin
            pushExp(0, 4, d, due);
        end else if (d[4:3] == 2'b00) begin
            pushExp(0, 5, d, due);
        end else if (d[4:3] == 2'b01) begin
            if (d[1]) mRdIsr = d[0];
            pushExp(0, 6, d, due);
        end else begin
            pushExp(1, 0, d, due);
        end
    endfunction

    task automatic waitDrain();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("drained", expQ.size(), 0);
        expQ.delete();
        checkOutput("init_done", int'(bus.init_done), int'(modelReady()));
    endtask

    task automatic applyStimulus(input bit isWrite, input bit a0v, input logic [7:0] d,
                                 input bit csv, input bit withRd, input int hold);
        int c0;
        @(posedge clk);
        #2;
        c0 = cycleCnt;
        if (isWrite) begin
            if (csv) modelWrite(a0v, d, c0 + 2 + hold);
            for (int i = 0; i <= hold; i++) begin
                bus.cs_n    = ~csv;
                bus.wr_n    = 1'b0;
                bus.rd_n    = ~withRd;
                bus.a0      = a0v;
                bus.data_in = (i < hold) ? ~d : d;
                @(posedge clk);
                #2;
            end
        end else begin
            if (csv) pushExp(2, a0v ? 3 : (mRdIsr ? 5 : 1), 8'h00, c0 + 1);
            bus.cs_n = ~csv;
            bus.rd_n = 1'b0;
            bus.a0   = a0v;
            @(posedge clk);
            #2;
        end
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.rd_n = 1'b1;
        waitDrain();
    endtask

    task automatic checkResetValues();
        checkOutput("rst_flag",     int'(bus.cmd_flag),  7);
        checkOutput("rst_valid",    int'(bus.cmd_valid), 0);
        checkOutput("rst_data",     int'(bus.cmd_data),  0);
        checkOutput("rst_read_sel", int'(bus.read_sel),  0);
        checkOutput("rst_init",     int'(bus.init_done), 0);
        checkOutput("rst_seq_err",  int'(bus.seq_error), 0);
    endtask

    // Monitor: every output event is matched against the oldest expected response.
    always @(negedge clk) begin
        if (cycleCnt >= 1) begin
            if (bus.cmd_valid || bus.seq_error || (bus.read_sel != 3'b000)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_event", 1, 0);
                end else begin
                    exp_t e;
                    int   kind;
                    e = expQ.pop_front();
                    kind = bus.cmd_valid ? 0 : (bus.seq_error ? 1 : 2);
                    checkOutput("event_kind", kind, e.kind);
                    checkOutput("latency", cycleCnt, e.due);
                    if (e.kind == 0) begin
                        checkOutput("cmd_flag", int'(bus.cmd_flag), int'(e.code));
                        checkOutput("cmd_data", int'(bus.cmd_data), int'(e.data));
                    end else if (e.kind == 2) begin
                        checkOutput("read_sel", int'(bus.read_sel), int'(e.code));
                    end
                end
            end
            if (!bus.cmd_valid)
                checkOutput("idle_flag", int'(bus.cmd_flag), 7);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         a0v;
        checks = 0;
        errors = 0;
        modelReset();
        reset_n     = 1'b0;
        bus.cs_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.rd_n    = 1'b1;
        bus.a0      = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        checkResetValues();
        reset_n = 1'b1;

        $display("[TB] single mode init");
        applyStimulus(1, 0, 8'h13, 1, 0, 0);
        applyStimulus(1, 1, 8'h20, 1, 0, 0);
        applyStimulus(1, 1, 8'h01, 1, 0, 0);

        $display("[TB] cascade init");
        applyStimulus(1, 0, 8'h11, 1, 0, 0);
        applyStimulus(1, 1, 8'h40, 1, 0, 0);
        applyStimulus(1, 1, 8'h04, 1, 0, 0);
        applyStimulus(1, 1, 8'h1D, 1, 0, 0);

        $display("[TB] operational words and reads");
        applyStimulus(1, 1, 8'hF0, 1, 0, 0);
        applyStimulus(1, 0, 8'h20, 1, 0, 0);
        applyStimulus(1, 0, 8'h0B, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        applyStimulus(0, 1, 8'h00, 1, 0, 0);

        $display("[TB] illegal word and restart");
        applyStimulus(1, 0, 8'h13, 1, 0, 0);
        applyStimulus(1, 0, 8'h0A, 1, 0, 0);
        applyStimulus(1, 1, 8'h20, 1, 0, 0);
        applyStimulus(1, 0, 8'h13, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);

        $display("[TB] long strobe, deselected and overlapping strobes");
        applyStimulus(1, 1, 8'h55, 1, 0, 2);
        applyStimulus(1, 1, 8'h01, 1, 0, 1);
        applyStimulus(1, 1, 8'h3C, 0, 0, 0);
        applyStimulus(1, 1, 8'hA5, 1, 1, 0);
        applyStimulus(0, 1, 8'h00, 0, 0, 0);

        $display("[TB] reset during write");
        @(posedge clk);
        #2;
        bus.cs_n    = 1'b0;
        bus.wr_n    = 1'b0;
        bus.a0      = 1'b1;
        bus.data_in = 8'hAA;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n  = 1'b1;
        bus.wr_n = 1'b1;
        bus.cs_n = 1'b1;
        modelReset();
        waitDrain();
        checkResetValues();
        applyStimulus(1, 1, 8'hF0, 1, 0, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            d   = 8'($urandom_range(0, 255));
            a0v = 1'($urandom_range(0, 1));
            if (!a0v && ($urandom_range(0, 7) != 0)) d[4] = 1'b0;
            applyStimulus(($urandom_range(0, 2) != 0), a0v, d,
                          ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                          $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
